// File: rtl/uart_pkg.sv
// Shared UART types: baud controller states, divisor source tags, and the
// divisor width used by both the baud generator and its controller.
package uart_pkg;

   localparam int unsigned BAUD_DVSR_W = 11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      APPLY     = 2'd1,
      AUTO_ARM  = 2'd2,
      AUTO_MEAS = 2'd3
   } baud_ctrl_state_e;

   typedef enum logic {
      MAN  = 1'b0,
      AUTO = 1'b1
   } baud_src_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency.
// The reset value is a parameter so idle-high lines start out idle.
module sync_2ff #(
   parameter bit RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud divisor owner: takes manual (valid/ready) or auto-baud measured divisors
// and commits them only on a generator tick; no backpressure beyond cfg_ready.
module uart_baud_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DVSR_W   = BAUD_DVSR_W,
   parameter int unsigned RST_DVSR = 26,
   parameter int unsigned MIN_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DVSR_W-1:0] cfg_dvsr,
   input  logic              auto_start,
   input  logic              rx,
   input  logic              tick,
   output logic [DVSR_W-1:0] dvsr,
   output logic              busy,
   output logic              auto_done,
   output logic              auto_err
);

   localparam logic [DVSR_W:0] CNT_ONE = (DVSR_W+1)'(1);
   localparam logic [DVSR_W:0] CNT_MAX = {1'b1, {DVSR_W{1'b0}}};
   localparam logic [DVSR_W:0] MIN_CNT = (DVSR_W+1)'(MIN_W);

   baud_ctrl_state_e  state_q,   state_d;
   baud_src_e         src_q,     src_d;
   logic [DVSR_W:0]   cnt_q,     cnt_d;
   logic [DVSR_W-1:0] pending_q, pending_d;
   logic [DVSR_W-1:0] dvsr_q,    dvsr_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic              err_q,     err_d;
   logic              rx_prev_q, rx_prev_d;
   logic              rx_s;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   assign cfg_ready = (state_q == IDLE) && !auto_start;

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      dvsr_d    = dvsr_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rx_prev_d = rx_s;

      case (state_q)
         IDLE: begin
            // auto_start has priority; cfg_ready is already low when it is set
            if (auto_start) begin
               state_d = AUTO_ARM;
            end else if (cfg_valid) begin
               pending_d = cfg_dvsr;
               src_d     = MAN;
               state_d   = APPLY;
            end
         end
         AUTO_ARM: begin
            if (rx_prev_q && !rx_s) begin
               cnt_d   = CNT_ONE;
               state_d = AUTO_MEAS;
            end
         end
         AUTO_MEAS: begin
            if (!rx_s) begin
               if (cnt_q == CNT_MAX) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else if (cnt_q < MIN_CNT) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               pending_d = DVSR_W'(cnt_q - CNT_ONE);
               src_d     = AUTO;
               state_d   = APPLY;
            end
         end
         APPLY: begin
            if (tick) begin
               dvsr_d  = pending_q;
               done_d  = (src_q == AUTO);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         src_q     <= MAN;
         cnt_q     <= '0;
         pending_q <= '0;
         dvsr_q    <= DVSR_W'(RST_DVSR);
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rx_prev_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         dvsr_q    <= dvsr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rx_prev_q <= rx_prev_d;
      end
   end

   assign dvsr      = dvsr_q;
   assign busy      = busy_q;
   assign auto_done = done_q;
   assign auto_err  = err_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Bench for uart_baud_ctrl: vector tables for manual and auto-baud updates,
// a queue of expected divisors checked whenever dvsr moves, plus reset cases.
module tb_uart_baud_ctrl;

   localparam int DW = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [DW-1:0] cfg_dvsr = '0;
   logic          auto_start = 1'b0;
   logic          rx = 1'b1;
   logic          tick = 1'b0;
   logic [DW-1:0] dvsr;
   logic          busy;
   logic          auto_done;
   logic          auto_err;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] cur_dvsr;

   typedef struct {
      logic [DW-1:0] val;
      int            delay;
      bit            tick_at_acc;
      logic [DW-1:0] exp_dvsr;
   } man_vec_t;

   typedef struct {
      int            len;
      bit            exp_err;
      logic [DW-1:0] exp_dvsr;
   } auto_vec_t;

   uart_baud_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_dvsr   (cfg_dvsr),
      .auto_start (auto_start),
      .rx         (rx),
      .tick       (tick),
      .dvsr       (dvsr),
      .busy       (busy),
      .auto_done  (auto_done),
      .auto_err   (auto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every dvsr movement outside reset must match the oldest queued value.
   initial begin : monitor
      logic [DW-1:0] prev;
      prev = dvsr;
      forever begin
         @(posedge clk);
         #3;
         if (auto_done) done_cnt++;
         if (auto_err) err_cnt++;
         if (rst) begin
            prev = dvsr;
         end else if (dvsr !== prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: dvsr moved to %0d with nothing queued", dvsr);
            end else begin
               chk("sb_dvsr", 32'(dvsr), 32'(exp_q.pop_front()));
            end
            prev = dvsr;
         end
      end
   end

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      man_vec_t  mv[5];
      auto_vec_t av[8];
      int d0, e0;

      mv[0] = '{val: 11'd10,   delay: 5, tick_at_acc: 1'b1, exp_dvsr: 11'd10};
      mv[1] = '{val: 11'd0,    delay: 1, tick_at_acc: 1'b0, exp_dvsr: 11'd0};
      mv[2] = '{val: 11'd2047, delay: 3, tick_at_acc: 1'b1, exp_dvsr: 11'd2047};
      mv[3] = '{val: 11'd300,  delay: 7, tick_at_acc: 1'b0, exp_dvsr: 11'd300};
      mv[4] = '{val: 11'd26,   delay: 2, tick_at_acc: 1'b0, exp_dvsr: 11'd26};

      av[0] = '{len: 2,    exp_err: 1'b1, exp_dvsr: 11'd26};
      av[1] = '{len: 3,    exp_err: 1'b1, exp_dvsr: 11'd26};
      av[2] = '{len: 4,    exp_err: 1'b0, exp_dvsr: 11'd3};
      av[3] = '{len: 2048, exp_err: 1'b0, exp_dvsr: 11'd2047};
      av[4] = '{len: 2049, exp_err: 1'b1, exp_dvsr: 11'd2047};
      av[5] = '{len: 3000, exp_err: 1'b1, exp_dvsr: 11'd2047};
      av[6] = '{len: 5,    exp_err: 1'b0, exp_dvsr: 11'd4};
      av[7] = '{len: 160,  exp_err: 1'b0, exp_dvsr: 11'd159};

      // Reset held
      repeat (3) cyc();
      chk("rst_dvsr", 32'(dvsr), 32'd26);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(auto_done), 32'd0);
      chk("rst_err", 32'(auto_err), 32'd0);
      rst = 1'b0;
      cur_dvsr = 11'd26;
      cyc();

      // Manual updates
      for (int i = 0; i < 5; i++) begin
         cfg_valid = 1'b1;
         cfg_dvsr  = mv[i].val;
         tick      = mv[i].tick_at_acc;
         #1;
         chk("man_cfg_ready", 32'(cfg_ready), 32'd1);
         exp_q.push_back(mv[i].exp_dvsr);
         cyc();
         cfg_valid = 1'b0;
         cfg_dvsr  = 11'd99;
         tick      = 1'b0;
         for (int k = 1; k < mv[i].delay; k++) begin
            chk("man_busy_wait", 32'(busy), 32'd1);
            chk("man_dvsr_hold", 32'(dvsr), 32'(cur_dvsr));
            cyc();
         end
         chk("man_busy_last", 32'(busy), 32'd1);
         chk("man_dvsr_last", 32'(dvsr), 32'(cur_dvsr));
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         chk("man_dvsr_new", 32'(dvsr), 32'(mv[i].exp_dvsr));
         chk("man_busy_done", 32'(busy), 32'd0);
         chk("man_no_done", 32'(auto_done), 32'd0);
         cur_dvsr = mv[i].exp_dvsr;
         cyc();
      end

      // Auto-baud: every start collides with a cfg request, which must lose
      for (int i = 0; i < 8; i++) begin
         d0 = done_cnt;
         e0 = err_cnt;
         auto_start = 1'b1;
         cfg_valid  = 1'b1;
         cfg_dvsr   = 11'd7;
         #1;
         chk("auto_contention_ready", 32'(cfg_ready), 32'd0);
         cyc();
         auto_start = 1'b0;
         cfg_valid  = 1'b0;
         chk("auto_busy_arm", 32'(busy), 32'd1);
         if (!av[i].exp_err) exp_q.push_back(av[i].exp_dvsr);
         rx = 1'b0;
         for (int k = 0; k < av[i].len; k++) begin
            if (av[i].len <= 2049 && (k % 40) == 0)
               chk("auto_meas_ready", 32'(cfg_ready), 32'd0);
            cyc();
         end
         rx = 1'b1;
         repeat (4) cyc();
         if (!av[i].exp_err) begin
            chk("auto_apply_busy", 32'(busy), 32'd1);
            chk("auto_apply_ready", 32'(cfg_ready), 32'd0);
            chk("auto_apply_hold", 32'(dvsr), 32'(cur_dvsr));
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            chk("auto_dvsr", 32'(dvsr), 32'(av[i].exp_dvsr));
            chk("auto_done_pulse", 32'(auto_done), 32'd1);
            cyc();
            chk("auto_done_clear", 32'(auto_done), 32'd0);
            chk("auto_busy_clear", 32'(busy), 32'd0);
            chk("auto_done_count", 32'(done_cnt - d0), 32'd1);
            chk("auto_err_none", 32'(err_cnt - e0), 32'd0);
         end else begin
            chk("err_idle", 32'(busy), 32'd0);
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
            chk("err_dvsr_kept", 32'(dvsr), 32'(cur_dvsr));
            chk("err_count", 32'(err_cnt - e0), 32'd1);
            chk("err_no_done", 32'(done_cnt - d0), 32'd0);
         end
         cur_dvsr = av[i].exp_dvsr;
         repeat (2) cyc();
      end

      // Asynchronous reset in the middle of a measurement
      d0 = done_cnt;
      e0 = err_cnt;
      auto_start = 1'b1;
      cyc();
      auto_start = 1'b0;
      rx = 1'b0;
      repeat (50) cyc();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_dvsr", 32'(dvsr), 32'd26);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(cfg_ready), 32'd1);
      rx = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
      cur_dvsr = 11'd26;
      tick = 1'b1;
      repeat (10) cyc();
      tick = 1'b0;
      chk("arst_dvsr_after", 32'(dvsr), 32'd26);
      chk("arst_busy_after", 32'(busy), 32'd0);
      chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("arst_no_err", 32'(err_cnt - e0), 32'd0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
